// File: rtl/cipher_job_sequencer.sv
// Job front-end for the iterative block cipher core: job FIFO, enable sequencing, in-order results.
// Optional watchdog abort of a stuck core is enabled by defining CIPHER_SEQ_TIMEOUT_EN.
module cipher_job_sequencer #(
    parameter int unsigned DATA_W  = 36,
    parameter int unsigned KEY_W   = 144,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 127,
    parameter int unsigned GAP     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [DATA_W-1:0] job_data,
    input  logic [KEY_W-1:0]  job_key,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_timeout,
    output logic [DATA_W-1:0] core_S_I,
    output logic [KEY_W-1:0]  core_keyin,
    output logic              core_encrypt_en,
    input  logic              core_encr_done,
    input  logic [DATA_W-1:0] core_S_j,
    output logic              busy,
    output logic [15:0]       jobs_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
`ifdef CIPHER_SEQ_TIMEOUT_EN
    localparam int unsigned RW = $clog2(TIMEOUT);
`else
    localparam int unsigned RW = 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [KEY_W-1:0]  fifo_key_q  [DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full, push, pop;

    logic [DATA_W-1:0] op_data_q, op_data_d;
    logic [KEY_W-1:0]  op_key_q, op_key_d;
    logic [RW-1:0]     run_cnt_q, run_cnt_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [15:0]       jobs_done_q, jobs_done_d;
`ifdef CIPHER_SEQ_TIMEOUT_EN
    logic              cap_to_q, cap_to_d;
    logic              res_to_q, res_to_d;
`endif
    logic              en;

    // Flags derive only from registered pointers, so a same-cycle pop cannot raise job_ready.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = job_valid && !fifo_full;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;

    always_comb begin
        state_d     = state_q;
        op_data_d   = op_data_q;
        op_key_d    = op_key_q;
        run_cnt_d   = run_cnt_q;
        cap_d       = cap_q;
        gap_cnt_d   = gap_cnt_q;
        res_valid_d = res_valid_q && !res_ready;
        res_data_d  = res_data_q;
        jobs_done_d = (res_valid_q && res_ready) ? jobs_done_q + 16'd1 : jobs_done_q;
`ifdef CIPHER_SEQ_TIMEOUT_EN
        cap_to_d    = cap_to_q;
        res_to_d    = res_to_q;
`endif
        en          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    op_data_d = fifo_data_q[rd_ptr_q[AW-1:0]];
                    op_key_d  = fifo_key_q[rd_ptr_q[AW-1:0]];
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                run_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                en = 1'b1;
`ifdef CIPHER_SEQ_TIMEOUT_EN
                run_cnt_d = run_cnt_q + 1'b1;
`else
                // Without the watchdog only "past the first RUN cycle" matters.
                run_cnt_d = 1'b1;
`endif
                if ((run_cnt_q != '0) && core_encr_done) begin
                    cap_d   = core_S_j;
`ifdef CIPHER_SEQ_TIMEOUT_EN
                    cap_to_d = 1'b0;
`endif
                    state_d = S_DRAIN;
                end
`ifdef CIPHER_SEQ_TIMEOUT_EN
                else if (run_cnt_q == RW'(TIMEOUT - 1)) begin
                    cap_d    = '0;
                    cap_to_d = 1'b1;
                    state_d  = S_DRAIN;
                end
`endif
            end
            S_DRAIN: begin
                if (!res_valid_q || res_ready) begin
                    res_valid_d = 1'b1;
                    res_data_d  = cap_q;
`ifdef CIPHER_SEQ_TIMEOUT_EN
                    res_to_d    = cap_to_q;
`endif
                    gap_cnt_d   = '0;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GW'(GAP - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q[AW-1:0]] <= job_data;
            fifo_key_q[wr_ptr_q[AW-1:0]]  <= job_key;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            op_data_q   <= '0;
            op_key_q    <= '0;
            run_cnt_q   <= '0;
            cap_q       <= '0;
            gap_cnt_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            jobs_done_q <= '0;
`ifdef CIPHER_SEQ_TIMEOUT_EN
            cap_to_q    <= 1'b0;
            res_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            op_data_q   <= op_data_d;
            op_key_q    <= op_key_d;
            run_cnt_q   <= run_cnt_d;
            cap_q       <= cap_d;
            gap_cnt_q   <= gap_cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            jobs_done_q <= jobs_done_d;
`ifdef CIPHER_SEQ_TIMEOUT_EN
            cap_to_q    <= cap_to_d;
            res_to_q    <= res_to_d;
`endif
        end
    end

    assign job_ready       = !fifo_full;
    assign res_valid       = res_valid_q;
    assign res_data        = res_data_q;
`ifdef CIPHER_SEQ_TIMEOUT_EN
    assign res_timeout     = res_to_q;
`else
    assign res_timeout     = 1'b0;
`endif
    assign core_S_I        = op_data_q;
    assign core_keyin      = op_key_q;
    assign core_encrypt_en = en;
    assign busy            = (state_q != S_IDLE) || !fifo_empty;
    assign jobs_done       = jobs_done_q;

endmodule
